mem_port_arbiter: RTL

//  Shares the single-port Memory (clock, A, D, WE, WD) between the instruction-fetch

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the instruction-fetch and load/store ports.
// Optional grant/conflict counters are compiled in with MEM_ARB_STATS_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int WAIT_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  state_t              r_state;
  state_t              w_next;
  logic                r_owner_d;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wd;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_i_done;
  logic                r_d_done;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_any;
  logic                w_conflict;
  logic                w_fetch_wins;
  logic                w_grant;
  logic                w_busy;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_any        = i_req | d_req;
  assign w_conflict   = i_req & d_req;
  // With both requesting, fetch wins only once it has lost enough ties in a row.
  assign w_fetch_wins = i_req & (~d_req | (r_wait_cnt >= LIMIT));
  assign w_grant      = (r_state == S_IDLE) & w_any;
  assign w_busy       = (r_state == S_BUSY);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset gates the write strobe and done pulses combinationally so a reset
  // arriving in BUSY or RESP cancels the write / response in that same cycle.
  always_comb begin
    mem_addr = r_addr;
    mem_wd   = r_wd;
    mem_we   = w_busy & r_we & ~reset;
    i_done   = r_i_done & ~reset;
    d_done   = r_d_done & ~reset;
    i_rdata  = r_i_rdata;
    d_rdata  = r_d_rdata;
  end

  // Grant: latch the winner's request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
    end else if (w_grant) begin
      r_owner_d <= ~w_fetch_wins;
      r_we      <= w_fetch_wins ? 1'b0 : d_we;
      r_addr    <= w_fetch_wins ? i_addr : d_addr;
      r_wd      <= w_fetch_wins ? '0 : d_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_grant) begin
      if (w_fetch_wins)    r_wait_cnt <= '0;
      else if (w_conflict) r_wait_cnt <= sat_inc(r_wait_cnt);
    end
  end

  // Access: capture read data, arm the owner's done for RESP
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_done <= w_busy & ~r_owner_d;
      r_d_done <= w_busy & r_owner_d;
      if (w_busy & ~r_owner_d)         r_i_rdata <= mem_rd;
      if (w_busy & r_owner_d & ~r_we)  r_d_rdata <= mem_rd;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_i;
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
      r_stat_c <= '0;
    end else if (w_grant) begin
      if (w_fetch_wins) r_stat_i <= r_stat_i + 32'd1;
      else              r_stat_d <= r_stat_d + 32'd1;
      if (w_conflict)   r_stat_c <= r_stat_c + 32'd1;
    end
  end

  assign stat_i_grants  = r_stat_i;
  assign stat_d_grants  = r_stat_d;
  assign stat_conflicts = r_stat_c;
`endif

endmodule
